// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the data-side memory-map port.
// Registered slave side with wait states, timeout and a pipeline stall.
module mem_bus_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 15,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_m0_req,
  input  logic                  i_m0_we,
  input  logic [DATA_WIDTH-1:0] i_m0_addr,
  input  logic [DATA_WIDTH-1:0] i_m0_wdata,
  output logic                  o_m0_ack,
  output logic                  o_m0_err,
  output logic [DATA_WIDTH-1:0] o_m0_rdata,
  output logic                  o_m0_stall,
  input  logic                  i_m1_req,
  input  logic                  i_m1_we,
  input  logic [DATA_WIDTH-1:0] i_m1_addr,
  input  logic [DATA_WIDTH-1:0] i_m1_wdata,
  output logic                  o_m1_ack,
  output logic                  o_m1_err,
  output logic [DATA_WIDTH-1:0] o_m1_rdata,
  output logic                  o_s_re,
  output logic                  o_s_we,
  output logic [DATA_WIDTH-1:0] o_s_addr,
  output logic [DATA_WIDTH-1:0] o_s_wdata,
  input  logic [DATA_WIDTH-1:0] i_s_rdata,
  input  logic                  i_s_ready
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            state;
  logic                  last_grant;
  logic                  grant;
  logic [CW-1:0]         cnt;
  logic                  s_re;
  logic                  s_we;
  logic [DATA_WIDTH-1:0] s_addr;
  logic [DATA_WIDTH-1:0] s_wdata;
  logic                  m0_ack;
  logic                  m0_err;
  logic [DATA_WIDTH-1:0] m0_rdata;
  logic                  m1_ack;
  logic                  m1_err;
  logic [DATA_WIDTH-1:0] m1_rdata;

  logic                  any_req;
  logic                  sel;
  logic                  sel_we;
  logic [DATA_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  fin;
  logic                  fin_err;
  logic [DATA_WIDTH-1:0] fin_data;

  always_comb begin
    any_req = i_m0_req | i_m1_req;
    // On a tie the master that did not win last time goes first
    sel = (i_m0_req & i_m1_req) ? ~last_grant : i_m1_req;
    sel_we = sel ? i_m1_we : i_m0_we;
    sel_addr = sel ? i_m1_addr : i_m0_addr;
    sel_wdata = sel ? i_m1_wdata : i_m0_wdata;
    fin = i_s_ready | (cnt == CNT_LAST);
    fin_err = ~i_s_ready;
    fin_data = '0;
    if (!i_s_ready) begin
      fin_data = ERR_DATA;
    end else if (!s_we) begin
      fin_data = i_s_rdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      grant <= 1'b0;
      cnt <= '0;
      s_re <= 1'b0;
      s_we <= 1'b0;
      s_addr <= '0;
      s_wdata <= '0;
      m0_ack <= 1'b0;
      m0_err <= 1'b0;
      m0_rdata <= '0;
      m1_ack <= 1'b0;
      m1_err <= 1'b0;
      m1_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant <= sel;
            last_grant <= sel;
            s_addr <= sel_addr;
            s_wdata <= sel_wdata;
            s_we <= sel_we;
            s_re <= ~sel_we;
            cnt <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (fin) begin
            s_re <= 1'b0;
            s_we <= 1'b0;
            state <= RESP;
            if (grant) begin
              m1_ack <= 1'b1;
              m1_err <= fin_err;
              m1_rdata <= fin_data;
            end else begin
              m0_ack <= 1'b1;
              m0_err <= fin_err;
              m0_rdata <= fin_data;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          m0_ack <= 1'b0;
          m0_err <= 1'b0;
          m1_ack <= 1'b0;
          m1_err <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_m0_ack = m0_ack;
  assign o_m0_err = m0_err;
  assign o_m0_rdata = m0_rdata;
  assign o_m0_stall = i_m0_req & ~m0_ack;
  assign o_m1_ack = m1_ack;
  assign o_m1_err = m1_err;
  assign o_m1_rdata = m1_rdata;
  assign o_s_re = s_re;
  assign o_s_we = s_we;
  assign o_s_addr = s_addr;
  assign o_s_wdata = s_wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed steps plus random accesses
// checked against a transaction-level round-robin/latency model.
module tb_mem_bus_arbiter;

  localparam int TO = 15;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [1:0]  ack;
  logic [1:0]  err;
  logic [31:0] rdata [2];
  logic        m0_stall;
  logic        s_re;
  logic        s_we;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [31:0] s_rdata;
  logic        s_ready;

  int          errors = 0;
  int          checks = 0;
  int          wait_n = 0;
  int          busy_cnt = 0;
  int          exp_last = 1;
  logic [31:0] exp_rd [2];

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TO),
    .ERR_DATA(ERR)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_m0_req(req[0]),
    .i_m0_we(we[0]),
    .i_m0_addr(addr[0]),
    .i_m0_wdata(wdata[0]),
    .o_m0_ack(ack[0]),
    .o_m0_err(err[0]),
    .o_m0_rdata(rdata[0]),
    .o_m0_stall(m0_stall),
    .i_m1_req(req[1]),
    .i_m1_we(we[1]),
    .i_m1_addr(addr[1]),
    .i_m1_wdata(wdata[1]),
    .o_m1_ack(ack[1]),
    .o_m1_err(err[1]),
    .o_m1_rdata(rdata[1]),
    .o_s_re(s_re),
    .o_s_we(s_we),
    .o_s_addr(s_addr),
    .o_s_wdata(s_wdata),
    .i_s_rdata(s_rdata),
    .i_s_ready(s_ready)
  );

  // Slave answers after wait_n strobed cycles of the current access
  always @(posedge clk) busy_cnt <= (s_re | s_we) ? busy_cnt + 1 : 0;
  assign s_ready = (s_re | s_we) && (busy_cnt == wait_n);

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int m, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    req[m] = 1'b1;
    we[m] = w;
    addr[m] = a;
    wdata[m] = d;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_s_re"}, 32'(s_re), 0);
    chk({tag, "_s_we"}, 32'(s_we), 0);
    chk({tag, "_s_addr"}, s_addr, 0);
    chk({tag, "_s_wdata"}, s_wdata, 0);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_rd0"}, rdata[0], 0);
    chk({tag, "_rd1"}, rdata[1], 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    req = 2'b00;
    repeat (n) tick();
    chk_zero("reset");
    rst = 1'b0;
    exp_last = 1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  // One arbitration from IDLE through the ack and back to IDLE
  task automatic one_grant(input int w, input logic [31:0] rd,
                           input bit drop);
    int who;
    int oth;
    int lat;
    bit to;
    logic [31:0] erd;
    logic ewe;
    logic [31:0] ea;
    logic [31:0] ed;
    #1;
    chk("stall_pre", 32'(m0_stall), 32'(req[0]));
    if (req[0] && req[1]) who = 1 - exp_last;
    else who = req[1] ? 1 : 0;
    oth = 1 - who;
    exp_last = who;
    ewe = we[who];
    ea = addr[who];
    ed = wdata[who];
    wait_n = w;
    s_rdata = rd;
    to = (w >= TO);
    lat = to ? TO : w + 1;
    erd = to ? ERR : (ewe ? 32'h0 : rd);
    tick();
    if (drop) req[who] = 1'b0;
    #1;
    for (int i = 0; i < lat; i++) begin
      chk("s_re", 32'(s_re), 32'(!ewe));
      chk("s_we", 32'(s_we), 32'(ewe));
      chk("s_addr", s_addr, ea);
      chk("s_wdata", s_wdata, ed);
      chk("ack_early", 32'(ack), 0);
      chk("stall_busy", 32'(m0_stall), 32'(req[0]));
      tick();
    end
    chk("ack_win", 32'(ack[who]), 1);
    chk("ack_oth", 32'(ack[oth]), 0);
    chk("err_win", 32'(err[who]), 32'(to));
    chk("rd_win", rdata[who], erd);
    chk("rd_oth", rdata[oth], exp_rd[oth]);
    chk("strobe_off", 32'({s_re, s_we}), 0);
    chk("stall_ack", 32'(m0_stall), 32'(req[0] && who != 0));
    exp_rd[who] = erd;
    req[who] = 1'b0;
    tick();
    chk("ack_clr", 32'(ack), 0);
    chk("err_clr", 32'(err), 0);
    chk("rd_hold", rdata[who], exp_rd[who]);
  endtask

  initial begin
    int r;
    int w;
    int m;
    rst = 1'b1;
    req = 2'b00;
    we = 2'b00;
    addr[0] = '0;
    addr[1] = '0;
    wdata[0] = '0;
    wdata[1] = '0;
    s_rdata = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    do_reset(3);

    set_m(0, 1'b0, 32'h10010004, 32'h0);
    one_grant(0, 32'h12345678, 1'b0);

    set_m(1, 1'b1, 32'h10010024, 32'hA5A5A5A5);
    one_grant(3, 32'h0BADF00D, 1'b0);

    do_reset(1);
    set_m(0, 1'b0, 32'h00000100, 32'h0);
    set_m(1, 1'b1, 32'h00000200, 32'h11112222);
    for (int k = 0; k < 6; k++) begin
      one_grant(0, 32'hC0DE0000 + 32'(k), 1'b0);
      if (k[0]) set_m(1, 1'b0, 32'h00000300 + 32'(k), 32'h0);
      else set_m(0, 1'b1, 32'h00000400 + 32'(k), 32'h33330000 + 32'(k));
    end
    req = 2'b00;
    tick();

    set_m(0, 1'b0, 32'h10000040, 32'h0);
    one_grant(100, 32'h55555555, 1'b0);
    set_m(0, 1'b0, 32'h10000044, 32'h0);
    one_grant(1, 32'h66666666, 1'b0);

    set_m(1, 1'b0, 32'h10000080, 32'h0);
    one_grant(2, 32'h77777777, 1'b1);

    set_m(0, 1'b0, 32'h10000090, 32'h0);
    wait_n = 50;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_zero("rst_mid");
    rst = 1'b0;
    req = 2'b00;
    exp_last = 1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    for (int i = 0; i < 6; i++) begin
      chk("rst_noack", 32'(ack), 0);
      tick();
    end
    set_m(0, 1'b1, 32'h000000A0, 32'hAAAA0000);
    set_m(1, 1'b1, 32'h000000B0, 32'hBBBB0000);
    one_grant(0, 32'h0, 1'b0);
    one_grant(1, 32'h0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      m = $urandom_range(1, 3);
      for (int j = 0; j < 2; j++) begin
        if (m[j]) begin
          set_m(j, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end
      end
      while (req != 2'b00) begin
        r = $urandom_range(0, 9);
        w = (r < 7) ? r : TO + r - 7;
        one_grant(w, $urandom, $urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
